// File: rtl/vending_pkg.sv
// Shared coin-interface definitions: 2-bit coin codes, denomination values,
// the dispenser state encoding and the per-denomination availability flags.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam int VAL_1 = 1;
  localparam int VAL_2 = 2;
  localparam int VAL_5 = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic c5;
    logic c2;
    logic c1;
  } avail_t;

  // coin_decode direction: code -> face value
  function automatic int coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return VAL_1;
      COIN_2:  return VAL_2;
      COIN_5:  return VAL_5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_encode.sv
// coin_encode: greedy pick of the largest available coin not exceeding
// the remaining change; COIN_NONE/0 when nothing is payable.
module coin_encode
  import vending_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] remaining,
  input  avail_t           avail,
  output logic [1:0]       code,
  output logic [WIDTH-1:0] value
);

  always_comb begin
    code  = COIN_NONE;
    value = '0;
    if (avail.c5 && remaining >= WIDTH'(VAL_5)) begin
      code  = COIN_5;
      value = WIDTH'(VAL_5);
    end else if (avail.c2 && remaining >= WIDTH'(VAL_2)) begin
      code  = COIN_2;
      value = WIDTH'(VAL_2);
    end else if (avail.c1 && remaining >= WIDTH'(VAL_1)) begin
      code  = COIN_1;
      value = WIDTH'(VAL_1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout: presents one coin per valid/ack handshake to the hopper.
// Optional COIN_INVENTORY_EN adds per-denomination stock counters and short-pay reporting.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int INV_WIDTH = 4,
  parameter int INV_INIT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [WIDTH-1:0] shortfall,
  input  logic             refill
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] enc_rem;
  logic [WIDTH-1:0] enc_val;
  logic [1:0]       enc_code;
  logic             load;
  logic             ack_take;
  avail_t           avail_nxt;

  assign ack_take = (state == PRESENT) && coin_ack;
  assign cur_val  = WIDTH'(coin_value(coin_out));
  // Next coin is chosen from what will remain after this cycle's event,
  // so coin_out can be registered and presented back-to-back.
  assign enc_rem  = (state == IDLE) ? amount : remaining - cur_val;

  coin_encode #(.WIDTH(WIDTH)) u_enc (
    .remaining (enc_rem),
    .avail     (avail_nxt),
    .code      (enc_code),
    .value     (enc_val)
  );

`ifdef COIN_INVENTORY_EN
  logic [INV_WIDTH-1:0] cnt5, cnt2, cnt1;
  logic [INV_WIDTH-1:0] cnt5_nxt, cnt2_nxt, cnt1_nxt;

  always_comb begin
    cnt5_nxt = cnt5;
    cnt2_nxt = cnt2;
    cnt1_nxt = cnt1;
    if (refill) begin
      cnt5_nxt = INV_WIDTH'(INV_INIT);
      cnt2_nxt = INV_WIDTH'(INV_INIT);
      cnt1_nxt = INV_WIDTH'(INV_INIT);
    end else if (ack_take) begin
      case (coin_out)
        COIN_5:  cnt5_nxt = cnt5 - INV_WIDTH'(1);
        COIN_2:  cnt2_nxt = cnt2 - INV_WIDTH'(1);
        COIN_1:  cnt1_nxt = cnt1 - INV_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt5 <= INV_WIDTH'(INV_INIT);
      cnt2 <= INV_WIDTH'(INV_INIT);
      cnt1 <= INV_WIDTH'(INV_INIT);
    end else begin
      cnt5 <= cnt5_nxt;
      cnt2 <= cnt2_nxt;
      cnt1 <= cnt1_nxt;
    end
  end

  assign avail_nxt = '{c5: (cnt5_nxt != '0), c2: (cnt2_nxt != '0), c1: (cnt1_nxt != '0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      short     <= 1'b0;
      shortfall <= '0;
    end else if (load && enc_code == COIN_NONE) begin
      short     <= (enc_rem != '0);
      shortfall <= enc_rem;
    end else begin
      short     <= 1'b0;
      shortfall <= '0;
    end
  end
`else
  logic unused_refill;
  localparam int unused_inv_cfg = INV_WIDTH + INV_INIT;
  assign unused_refill = refill;
  assign avail_nxt     = '{c5: 1'b1, c2: 1'b1, c1: 1'b1};
  assign short         = 1'b0;
  assign shortfall     = '0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = (enc_code != COIN_NONE) ? PRESENT : DONE;
      end
      PRESENT: if (coin_ack) begin
        load      = 1'b1;
        state_nxt = (enc_code != COIN_NONE) ? PRESENT : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      coin_out  <= COIN_NONE;
    end else begin
      state <= state_nxt;
      if (load) begin
        remaining <= enc_rem;
        coin_out  <= enc_code;
      end else if (state == DONE) begin
        coin_out  <= COIN_NONE;
      end
    end
  end

  assign coin_valid = (state == PRESENT);
  assign busy       = (state == PRESENT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy coin model feeds an expected-coin
// queue, popped on every hopper ack. Define COIN_INVENTORY_EN to exercise stock limits.
module tb_change_dispenser;
  import vending_pkg::*;

  localparam int WIDTH = 4;
`ifdef COIN_INVENTORY_EN
  localparam int  INV_INIT = 1;
  localparam bit  INV_EN   = 1'b1;
`else
  localparam int  INV_INIT = 15;
  localparam bit  INV_EN   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] amount = '0;
  logic             coin_ack = 1'b0;
  logic             refill = 1'b0;
  logic [1:0]       coin_out;
  logic             coin_valid, busy, done, short;
  logic [WIDTH-1:0] shortfall;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  int         inv5, inv2, inv1;
  bit         exp_short;
  int         exp_sf;

  always #5 clk = ~clk;

  change_dispenser #(.WIDTH(WIDTH), .INV_WIDTH(4), .INV_INIT(INV_INIT)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
    .busy(busy), .done(done), .short(short), .shortfall(shortfall),
    .refill(refill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_refill();
    inv5 = INV_INIT; inv2 = INV_INIT; inv1 = INV_INIT;
  endtask

  // Greedy payout model; pushes expected coins and records expected short-pay.
  task automatic model(input int amt);
    int rem;
    bit go;
    rem = amt;
    go  = 1'b1;
    while (go && rem > 0) begin
      if (rem >= 5 && inv5 > 0) begin
        exp_q.push_back(COIN_5); rem -= 5; if (INV_EN) inv5--;
      end else if (rem >= 2 && inv2 > 0) begin
        exp_q.push_back(COIN_2); rem -= 2; if (INV_EN) inv2--;
      end else if (rem >= 1 && inv1 > 0) begin
        exp_q.push_back(COIN_1); rem -= 1; if (INV_EN) inv1--;
      end else go = 1'b0;
    end
    exp_short = INV_EN && (rem != 0);
    exp_sf    = INV_EN ? rem : 0;
  endtask

  task automatic refill_pulse();
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
  endtask

  task automatic run(input int amt, input int delay, input bit mid_start);
    int         waitc, budget;
    logic [1:0] held, exp_c;
    bit         acked_prev, seen_done, first, injected;
    waitc = 0; budget = 0; held = COIN_NONE;
    acked_prev = 0; seen_done = 0; first = 1; injected = 0;
    model(amt);
    @(negedge clk); start = 1'b1; amount = WIDTH'(amt);
    @(negedge clk); start = 1'b0; amount = WIDTH'($urandom_range(0, 15));
    while (!seen_done && budget < 100) begin
      if (done) begin
        seen_done = 1'b1;
        check("done_latency", 32'(first || acked_prev), 1);
        check("short", short, exp_short);
        check("shortfall", shortfall, exp_sf);
        check("coins_left", exp_q.size(), 0);
        check("busy_valid_in_done", {busy, coin_valid}, 0);
        coin_ack = 1'b0;
      end else begin
        check("valid", coin_valid, 1);
        check("busy", busy, 1);
        if (waitc == 0) held = coin_out;
        else check("stable", coin_out, held);
        if (waitc == delay) begin
          check("coin_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_c = exp_q.pop_front();
            check("coin", coin_out, exp_c);
          end
          coin_ack = 1'b1; waitc = 0; acked_prev = 1'b1;
        end else begin
          coin_ack = 1'b0; waitc++; acked_prev = 1'b0;
        end
        if (mid_start && !injected) begin
          start = 1'b1; amount = 4'd7; injected = 1'b1;
        end else start = 1'b0;
      end
      first = 1'b0;
      budget++;
      @(negedge clk);
    end
    coin_ack = 1'b0; start = 1'b0;
    check("timeout", seen_done, 1);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    model_refill();
    repeat (2) @(negedge clk);
    check("rst_coin", coin_out, 0);
    check("rst_valid", coin_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", {short, shortfall}, 0);
    reset = 1'b0;

    refill_pulse(); run(13, 0, 1'b0);   // 11,11,10,01 back-to-back
    refill_pulse(); run(9, 3, 1'b0);    // 11,10,10 with slow hopper
    run(0, 0, 1'b0);                    // no coin, done in N+1
    refill_pulse(); run(13, 1, 1'b1);   // start during payout ignored

    // Reset after the second coin of 15 aborts the payout silently.
    refill_pulse();
    @(negedge clk); start = 1'b1; amount = 4'd15;
    @(negedge clk); start = 1'b0; coin_ack = 1'b1;
    @(negedge clk);
    @(negedge clk); coin_ack = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_refill();
    check("abort_outputs", {coin_out, coin_valid, busy, done, short, shortfall}, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", coin_valid, 0);
    end
    run(5, 0, 1'b0);

    // Stock-limited payout: short with remainder, then again after refill.
    refill_pulse(); run(13, 0, 1'b0);
    refill_pulse(); run(13, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
